// File: rtl/mux_tree_pipe_pkg.sv
// Shared sizing helpers for the pipelined mux tree: input count, stage count
// and how many words survive each pipeline stage.
package mux_tree_pipe_pkg;

    function automatic int unsigned num_in_f(input int unsigned sel_bits);
        return 32'd1 << sel_bits;
    endfunction

    // A zero level count is rejected by the top; return 1 so elaboration reaches that check.
    function automatic int unsigned nstg_f(input int unsigned sel_bits, input int unsigned lvls);
        if (lvls == 32'd0) begin
            return 32'd1;
        end else begin
            return (sel_bits + lvls - 32'd1) / lvls;
        end
    endfunction

    function automatic int unsigned lvls_before(input int unsigned s, input int unsigned sel_bits,
                                                input int unsigned lvls);
        if (s * lvls > sel_bits) begin
            return sel_bits;
        end else begin
            return s * lvls;
        end
    endfunction

    function automatic int unsigned words_after(input int unsigned s, input int unsigned sel_bits,
                                                input int unsigned lvls);
        return 32'd1 << (sel_bits - lvls_before(s + 32'd1, sel_bits, lvls));
    endfunction

    localparam int unsigned DEF_WIDTH          = 32'd16;
    localparam int unsigned DEF_SEL_BITS       = 32'd4;
    localparam int unsigned DEF_LVLS_PER_STAGE = 32'd2;
    localparam int unsigned NUM_IN             = num_in_f(DEF_SEL_BITS);
    localparam int unsigned NSTG               = nstg_f(DEF_SEL_BITS, DEF_LVLS_PER_STAGE);

endpackage

// File: rtl/mux_tree_stage.sv
// One pipeline stage of the mux tree: LEVELS levels of 2:1 reduction feeding a
// valid/data/sel register with its own local ready.
module mux_tree_stage
    import mux_tree_pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SEL_BITS = 4,
    parameter int unsigned IN_WORDS = 16,
    parameter int unsigned LEVELS   = 2,
    parameter int unsigned LVL_BASE = 0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   up_valid,
    output logic                                   up_ready,
    input  logic [IN_WORDS*WIDTH-1:0]              up_data,
    input  logic [SEL_BITS-1:0]                    up_sel,
    output logic                                   dn_valid,
    input  logic                                   dn_ready,
    output logic [(IN_WORDS >> LEVELS)*WIDTH-1:0]  dn_data,
    output logic [SEL_BITS-1:0]                    dn_sel
);

    localparam int unsigned OUT_WORDS = IN_WORDS >> LEVELS;

    logic                         valid_r;
    logic [OUT_WORDS*WIDTH-1:0]   data_r;
    logic [SEL_BITS-1:0]          sel_r;
    logic                         ready_s;
    logic [OUT_WORDS*WIDTH-1:0]   reduced_s;

    // Level l halves the word count using the global select bit LVL_BASE+l-1.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned NW = IN_WORDS >> l;
        logic [NW*WIDTH-1:0] word_s;
        if (l == 0) begin : g_leaf
            assign word_s = up_data;
        end else begin : g_red
            for (genvar j = 0; j < NW; j++) begin : g_mux
                assign word_s[j*WIDTH +: WIDTH] = up_sel[LVL_BASE + l - 1]
                    ? g_lvl[l-1].word_s[(2*j+1)*WIDTH +: WIDTH]
                    : g_lvl[l-1].word_s[(2*j)*WIDTH +: WIDTH];
            end
        end
    end

    assign reduced_s = g_lvl[LEVELS].word_s;
    assign ready_s   = ~valid_r | dn_ready;

    // Stage register: loads whenever empty or draining; otherwise holds bit-exact.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {(OUT_WORDS*WIDTH){1'b0}};
            sel_r   <= {SEL_BITS{1'b0}};
        end else if (ready_s) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= reduced_s;
                sel_r  <= up_sel;
            end
        end
    end

    assign up_ready = ready_s;
    assign dn_valid = valid_r;
    assign dn_data  = data_r;
    assign dn_sel   = sel_r;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N-to-1 mux tree with valid/ready handshake; the select rides
// along with its data so stalls never mix requests.
module mux_tree_pipe
    import mux_tree_pipe_pkg::*;
#(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned SEL_BITS       = 4,
    parameter int unsigned LVLS_PER_STAGE = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [num_in_f(SEL_BITS)*WIDTH-1:0]  data_in,
    input  logic [SEL_BITS-1:0]                  sel,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH-1:0]                     data_out,
    output logic [SEL_BITS-1:0]                  out_sel
);

    localparam int unsigned NUM_INPUTS = num_in_f(SEL_BITS);
    localparam int unsigned N_STG      = nstg_f(SEL_BITS, LVLS_PER_STAGE);

    if ((LVLS_PER_STAGE < 32'd1) || (LVLS_PER_STAGE > SEL_BITS)) begin : g_bad_lvls
        $error("mux_tree_pipe: LVLS_PER_STAGE must lie in 1..SEL_BITS");
    end

    // Each stage gets its own link signals so the ready chain never loops through one vector.
    for (genvar s = 0; s < N_STG; s++) begin : g_stg
        localparam int unsigned BASE = lvls_before(s, SEL_BITS, LVLS_PER_STAGE);
        localparam int unsigned NLV  = lvls_before(s + 1, SEL_BITS, LVLS_PER_STAGE) - BASE;
        localparam int unsigned WIN  = NUM_INPUTS >> BASE;
        localparam int unsigned WOUT = WIN >> NLV;

        logic                    up_valid_s;
        logic                    up_ready_s;
        logic [WIN*WIDTH-1:0]    up_data_s;
        logic [SEL_BITS-1:0]     up_sel_s;
        logic                    dn_valid_s;
        logic                    dn_ready_s;
        logic [WOUT*WIDTH-1:0]   dn_data_s;
        logic [SEL_BITS-1:0]     dn_sel_s;

        if (s == 0) begin : g_head
            assign up_valid_s = in_valid;
            assign up_data_s  = data_in;
            assign up_sel_s   = sel;
        end else begin : g_link
            assign up_valid_s = g_stg[s-1].dn_valid_s;
            assign up_data_s  = g_stg[s-1].dn_data_s;
            assign up_sel_s   = g_stg[s-1].dn_sel_s;
        end

        if (s == N_STG - 1) begin : g_tail
            assign dn_ready_s = out_ready;
        end else begin : g_mid
            assign dn_ready_s = g_stg[s+1].up_ready_s;
        end

        mux_tree_stage #(
            .WIDTH    (WIDTH),
            .SEL_BITS (SEL_BITS),
            .IN_WORDS (WIN),
            .LEVELS   (NLV),
            .LVL_BASE (BASE)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .up_valid (up_valid_s),
            .up_ready (up_ready_s),
            .up_data  (up_data_s),
            .up_sel   (up_sel_s),
            .dn_valid (dn_valid_s),
            .dn_ready (dn_ready_s),
            .dn_data  (dn_data_s),
            .dn_sel   (dn_sel_s)
        );
    end

    assign in_ready  = g_stg[0].up_ready_s;
    assign out_valid = g_stg[N_STG-1].dn_valid_s;
    assign data_out  = g_stg[N_STG-1].dn_data_s;
    assign out_sel   = g_stg[N_STG-1].dn_sel_s;

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N-to-1 multiplexer tree with a valid/ready handshake. It is the successor to the fixed 16/18-bit 2:1, 4:1 and 16:1 combinational muxes.
- Used in the processor datapath wherever a wide select, such as a register-file read port or a forwarding select, would otherwise break timing.
- The select travels down the pipeline with its data, so a stall never mixes operands from different requests.

Parameters:
- WIDTH, 16, data width per input in bits (≥1).
- SEL_BITS, 4, select width; the number of inputs is NUM_IN = 2**SEL_BITS (1..6).
- LVLS_PER_STAGE, 2, number of 2:1 mux levels between pipeline registers (1..SEL_BITS).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, a request is present on data_in/sel.
- in_ready, output, 1, the block accepts the request this cycle.
- data_in, input, WIDTH*NUM_IN, flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel, input, SEL_BITS, binary select; bit 0 drives the first (leaf) level.
- out_valid, output, 1, data_out holds a valid result.
- out_ready, input, 1, the consumer takes data_out this cycle.
- data_out, output, WIDTH, selected input.
- out_sel, output, SEL_BITS, the select that produced data_out (debug and forwarding tag).

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high: it acts only on a rising clk edge where reset=1.
- Structure: SEL_BITS levels of 2:1 muxes. Level k consumes sel[k].
- Stage boundaries: a register stage sits after every LVLS_PER_STAGE levels, and the final level is always registered.
- Stage count: NSTG = ceil(SEL_BITS/LVLS_PER_STAGE).
- Latency: exactly NSTG cycles from an accepted request to out_valid when there is no back-pressure. Defaults give NSTG=2.
- Stage contents: each stage s holds a valid bit v[s], the partially reduced data (NUM_IN >> levels-done words of WIDTH), and the unconsumed upper sel bits. The full original sel is also carried for out_sel.
- Handshake:
  - rdy[NSTG] = out_ready.
  - rdy[s] = ~v[s] | rdy[s+1].
  - in_ready = rdy[0].
  - Stage s loads on rdy[s]: v[s] <= valid from upstream (in_valid for s=0).
- Bubble collapse: independent per-stage ready means empty stages fill even while the output is stalled. NSTG requests can be buffered, giving full throughput of one request per cycle.
- Holding: a stage with v=1 and rdy=0 keeps its data and sel bit-exact.
- Output stability: while out_valid=1 and out_ready=0, data_out and out_sel must not change.
- Combinational paths: in_ready depends combinationally on out_ready through the rdy chain. No other combinational input-to-output path exists.
- Simultaneous events: the last stage can be consumed and a new request enter on the same edge, and every stage advances. There is no lost or duplicated request.
- Reset values: all v[s]=0, out_valid=0, data_out=0, out_sel=0, in_ready=1 in the cycle after reset.
- Reset mid-operation: all in-flight requests are dropped. No output is produced for them afterwards.
- Degenerate case: SEL_BITS=1 gives a single registered 2:1 stage with latency 1.
- Parameter checks: an illegal parameter (LVLS_PER_STAGE=0 or >SEL_BITS) is a elaboration-time error via a generate-time check.

Decomposition:
- Shared package: constants NUM_IN, NSTG, and a function computing the words remaining after stage s. Also shared by the testbench.
- One natural sub-module, mux_tree_stage. It is one pipeline stage, parametrised by WIDTH, number of input words and number of levels, and contains:
  - the combinational reduction, built as a generate loop of 2:1 muxes;
  - the valid/data/sel registers;
  - the local ready.
- The top instantiates NSTG stages.

Test Plan:
- Reset then single request, defaults: data_in word i = 16'hA000+i, sel=4'd11, out_ready=1 → out_valid rises exactly 2 cycles after acceptance, data_out=16'hA00B, out_sel=11.
- Back-to-back streaming: sel=0..15 on consecutive cycles, out_ready=1 → 16 outputs on consecutive cycles in order, data_out=16'hA000..16'hA00F, in_ready constantly 1.
- Back-pressure: hold out_ready=0 while issuing sel=3,7,9 → the first two are accepted, then in_ready=0 on the third; data_out stays 16'hA003 stable. Release → outputs 3,7,9 in order, no loss or duplication.
- Reset mid-stream: 2 requests in flight, assert reset one cycle → next cycle out_valid=0, data_out=0, in_ready=1. No stale result appears in the following 4 cycles.
- Parameter sweep (WIDTH=18, SEL_BITS=3, LVLS_PER_STAGE=1 → latency 3; SEL_BITS=1 → latency 1): random sel, data and out_ready for 10k cycles against a reference-model FIFO → all outputs match, order preserved.
